// File: rtl/mem_responder_pkg.sv
// Shared memory-bus definitions: command encoding, tag width and tag pool size.
// Also imported by the I-cache controller, so keep it free of responder-only items.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int MEM_TAG_W    = 4;
  localparam int NUM_MEM_TAGS = 15;
  localparam int MEM_CNT_W    = 5;

  // Tag 0 means "no tag": a rejected command or an idle completion port.
  localparam logic [MEM_TAG_W-1:0] NO_TAG = '0;

  // Command 3 is not a real command and falls through as BUS_NONE.
  function automatic logic is_bus_cmd(input logic [1:0] cmd);
    return (cmd == 2'(BUS_LOAD)) || (cmd == 2'(BUS_STORE));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor <-> memory bus with tagged, fixed-latency completions.
//
// Handshake: the requester presents proc2mem_command (LOAD/STORE = valid) with
// address and data; the responder answers in the same cycle on
// mem2proc_response. A nonzero response means the command was taken with that
// tag; zero means it was not taken and the requester must present it again.
// Completions appear later on mem2proc_tag/mem2proc_data for exactly one cycle
// and cannot be back-pressured.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [1:0]           proc2mem_command;
  logic [63:0]          proc2mem_addr;
  logic [63:0]          proc2mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [MEM_TAG_W-1:0] mem2proc_tag;
  logic [63:0]          mem2proc_data;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data
  );

endinterface

// File: rtl/mem_responder_tag_alloc.sv
// Lowest-free-tag picker over the busy vector; bit i of busy is tag i+1.
module mem_tag_alloc
  import mem_responder_pkg::*;
(
  input  logic [NUM_MEM_TAGS-1:0] busy,
  output logic [MEM_TAG_W-1:0]    tag,
  output logic                    valid
);

  // Scan high to low so the lowest free tag is the last one written.
  always_comb begin
    tag   = NO_TAG;
    valid = 1'b0;
    for (int i = NUM_MEM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        tag   = MEM_TAG_W'(i + 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Behavioural main-memory responder: accepts one load/store per cycle against a
// 15-entry tag pool and returns each tag a fixed MEM_LAT cycles after acceptance.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LAT   = 10,
  parameter int MEM_WORDS = 8192
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int                   AW      = $clog2(MEM_WORDS);
  localparam logic [MEM_CNT_W-1:0] LAT_CNT = MEM_CNT_W'(MEM_LAT);

  // Backing store; never reset, contents come from stores on the bus.
  logic [63:0] mem [MEM_WORDS];

  // Per-tag state, entry i belongs to tag i+1.
  logic [NUM_MEM_TAGS-1:0] busy;
  logic [MEM_CNT_W-1:0]    cnt      [NUM_MEM_TAGS];
  logic [63:0]             data_buf [NUM_MEM_TAGS];
  logic [NUM_MEM_TAGS-1:0] is_store;

  logic [MEM_TAG_W-1:0] free_tag;
  logic                 free_valid;
  logic [MEM_TAG_W-1:0] alloc_idx;
  logic                 cmd_store;
  logic                 accept;
  logic [AW-1:0]        word;
  logic [63:0]          rdata;
  logic [MEM_TAG_W-1:0] next_tag;
  logic [63:0]          next_data;
  logic [MEM_TAG_W-1:0] tag_q;
  logic [63:0]          data_q;
  logic                 unused_addr_bits;

  mem_tag_alloc u_alloc (
    .busy  (busy),
    .tag   (free_tag),
    .valid (free_valid)
  );

  // Accept decision and same-cycle response; nothing is taken while in reset.
  always_comb begin
    cmd_store = bus.proc2mem_command == 2'(BUS_STORE);
    accept    = !rst && is_bus_cmd(bus.proc2mem_command) && free_valid;
    word      = bus.proc2mem_addr[3 +: AW];
    alloc_idx = free_tag - MEM_TAG_W'(1);
  end

  assign rdata                 = mem[word];
  assign bus.mem2proc_response = accept ? free_tag : NO_TAG;
  assign bus.mem2proc_tag      = tag_q;
  assign bus.mem2proc_data     = data_q;

  // Address bits outside the word index are deliberately ignored (modulo wrap).
  assign unused_addr_bits = ^{bus.proc2mem_addr[63:3+AW], bus.proc2mem_addr[2:0]};

  // Pick the completion for the next cycle: the busy tag whose countdown will be
  // 1 next cycle. With MEM_LAT == 1 that is the tag being accepted right now.
  always_comb begin
    next_tag  = NO_TAG;
    next_data = '0;
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      if (busy[i] && cnt[i] == MEM_CNT_W'(2)) begin
        next_tag  = next_tag | MEM_TAG_W'(i + 1);
        next_data = next_data | (is_store[i] ? 64'd0 : data_buf[i]);
      end
    end
    if (MEM_LAT == 1 && accept) begin
      next_tag  = free_tag;
      next_data = cmd_store ? 64'd0 : rdata;
    end
  end

  // Tag lifetime: allocate on accept, count down, free when the countdown hits 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NUM_MEM_TAGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MEM_TAGS; i++) begin
        if (busy[i]) begin
          if (cnt[i] == MEM_CNT_W'(1)) begin
            busy[i] <= 1'b0;
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] - MEM_CNT_W'(1);
          end
        end
      end
      if (accept) begin
        busy[alloc_idx] <= 1'b1;
        cnt[alloc_idx]  <= LAT_CNT;
      end
    end
  end

  // Load data is snapshotted at accept so later stores cannot change it.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store[alloc_idx] <= cmd_store;
      if (!cmd_store) data_buf[alloc_idx] <= rdata;
    end
  end

  // Store write into the backing array.
  always_ff @(posedge clk) begin
    if (accept && cmd_store) mem[word] <= bus.proc2mem_data;
  end

  // Registered completion port; zero whenever no tag completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= NO_TAG;
      data_q <= '0;
    end else begin
      tag_q  <= next_tag;
      data_q <= next_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (MEM_LAT=10/8192 words, MEM_LAT=20/64
// words) against a transaction-level model (free-tag set, completion queue
// keyed by due cycle, word-array memory).
module tb_mem_responder;
  import mem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  cmd_d   [2];
  logic [63:0] addr_d  [2];
  logic [63:0] wdata_d [2];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  assign bus0.proc2mem_command = cmd_d[0];
  assign bus0.proc2mem_addr    = addr_d[0];
  assign bus0.proc2mem_data    = wdata_d[0];
  assign bus1.proc2mem_command = cmd_d[1];
  assign bus1.proc2mem_addr    = addr_d[1];
  assign bus1.proc2mem_data    = wdata_d[1];

  mem_responder #(.MEM_LAT(10), .MEM_WORDS(8192)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_responder #(.MEM_LAT(20), .MEM_WORDS(64))   dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // ---------------- reference model ----------------
  int cyc = 0;
  int lat   [2] = '{10, 20};
  int words [2] = '{8192, 64};
  bit          m_busy [2][16];
  logic [63:0] m_mem  [2][8192];
  // entry = {due cycle[31:0], tag[3:0], data[63:0]}
  logic [99:0] exp_q0 [$];
  logic [99:0] exp_q1 [$];

  logic [3:0]  exp_resp [2], exp_tag [2], obs_resp [2], obs_tag [2];
  logic [63:0] exp_data [2], obs_data [2];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [3:0] lowest_free(int d);
    for (int t = 1; t <= 15; t++) if (!m_busy[d][t]) return 4'(t);
    return 4'd0;
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [99:0] q_front(int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_push(int d, logic [99:0] e);
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
  endtask

  task automatic q_pop(int d);
    if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
  endtask

  task automatic model_update(int d);
    logic [99:0] ent;
    int w;
    if (rst) begin
      for (int t = 0; t < 16; t++) m_busy[d][t] = 1'b0;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    if (q_size(d) > 0) begin
      ent = q_front(d);
      if (ent[99:68] == 32'(cyc)) begin
        m_busy[d][ent[67:64]] = 1'b0;
        q_pop(d);
      end
    end
    if (exp_resp[d] != 4'd0) begin
      m_busy[d][exp_resp[d]] = 1'b1;
      w = int'((addr_d[d] >> 3) % 64'(words[d]));
      if (cmd_d[d] == 2'(BUS_LOAD)) begin
        q_push(d, {32'(cyc + lat[d]), exp_resp[d], m_mem[d][w]});
      end else begin
        m_mem[d][w] = wdata_d[d];
        q_push(d, {32'(cyc + lat[d]), exp_resp[d], 64'd0});
      end
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [63:0] rand_addr(int d, int word);
    logic [63:0] a;
    a = {$urandom, $urandom};
    if (d == 0) a[15:3] = 13'(word); else a[8:3] = 6'(word);
    return a;
  endfunction

  task automatic drive(int d, logic [1:0] cmd, logic [63:0] addr, logic [63:0] data);
    cmd_d[d]   = cmd;
    addr_d[d]  = addr;
    wdata_d[d] = data;
  endtask

  task automatic idle_all();
    drive(0, 2'(BUS_NONE), 64'd0, 64'd0);
    drive(1, 2'(BUS_NONE), 64'd0, 64'd0);
  endtask

  // One clock: sample at negedge with model expectations, advance model at posedge.
  task automatic step();
    logic [99:0] ent;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_resp[d] = (!rst && (cmd_d[d] == 2'd1 || cmd_d[d] == 2'd2)) ? lowest_free(d) : 4'd0;
      exp_tag[d]  = 4'd0;
      exp_data[d] = 64'd0;
      if (q_size(d) > 0) begin
        ent = q_front(d);
        if (ent[99:68] == 32'(cyc)) begin
          exp_tag[d]  = ent[67:64];
          exp_data[d] = ent[63:0];
        end
      end
    end
    obs_resp[0] = bus0.mem2proc_response;
    obs_tag[0]  = bus0.mem2proc_tag;
    obs_data[0] = bus0.mem2proc_data;
    obs_resp[1] = bus1.mem2proc_response;
    obs_tag[1]  = bus1.mem2proc_tag;
    obs_data[1] = bus1.mem2proc_data;
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 2'(BUS_LOAD), 64'h40, 64'd0);
    drive(1, 2'(BUS_STORE), 64'h40, 64'h1);
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_resp[d] !== 4'd0 || obs_tag[d] !== 4'd0 || obs_data[d] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got resp=%0d tag=%0d data=%h, want all 0", d, obs_resp[d], obs_tag[d], obs_data[d]);
      end
    end
    rst = 1'b0;
    idle_all();
    for (int i = 0; i < 3; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({obs_resp[d], obs_tag[d], obs_data[d]} !== {exp_resp[d], exp_tag[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cyc=%0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                   d, cyc - 1, obs_resp[d], obs_tag[d], obs_data[d], exp_resp[d], exp_tag[d], exp_data[d]);
        end
      end
    end
  endtask

  // Fill words 0..63 of both memories through the bus, retrying rejected stores.
  task automatic test_preload();
    int idx [2];
    int budget;
    idx[0] = 0; idx[1] = 0;
    budget = 0;
    while ((idx[0] < 64 || idx[1] < 64) && budget < 400) begin
      for (int d = 0; d < 2; d++) begin
        if (idx[d] < 64) drive(d, 2'(BUS_STORE), rand_addr(d, idx[d]), {$urandom, $urandom});
        else drive(d, 2'(BUS_NONE), 64'd0, 64'd0);
      end
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({obs_resp[d], obs_tag[d], obs_data[d]} !== {exp_resp[d], exp_tag[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL preload dut%0d cyc=%0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                   d, cyc - 1, obs_resp[d], obs_tag[d], obs_data[d], exp_resp[d], exp_tag[d], exp_data[d]);
        end
        if (cmd_d[d] == 2'(BUS_STORE) && obs_resp[d] != 4'd0) idx[d]++;
      end
      budget++;
    end
    n_cmp++;
    if (idx[0] < 64 || idx[1] < 64) begin
      n_fail++;
      $display("FAIL preload_budget: stored %0d/%0d words, want 64/64", idx[0], idx[1]);
    end
    idle_all();
    for (int i = 0; i < 25; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({obs_resp[d], obs_tag[d], obs_data[d]} !== {exp_resp[d], exp_tag[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL preload_drain dut%0d cyc=%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                   d, cyc - 1, obs_tag[d], obs_data[d], exp_tag[d], exp_data[d]);
        end
      end
    end
  endtask

  task automatic test_single_load();
    idle_all();
    drive(0, 2'(BUS_STORE), 64'h100, 64'hDEAD);
    step();
    idle_all();
    for (int i = 0; i < 12; i++) step();
    drive(0, 2'(BUS_LOAD), 64'h100, 64'd0);
    step();
    n_cmp++;
    if (obs_resp[0] !== 4'd1) begin
      n_fail++;
      $display("FAIL single_load_resp: got %0d want 1", obs_resp[0]);
    end
    idle_all();
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (obs_tag[0] !== ((k == 10) ? 4'd1 : 4'd0) || obs_data[0] !== ((k == 10) ? 64'hDEAD : 64'd0)) begin
        n_fail++;
        $display("FAIL single_load_return +%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                 k, obs_tag[0], obs_data[0], (k == 10) ? 1 : 0, (k == 10) ? 64'hDEAD : 64'd0);
      end
      n_cmp++;
      if ({obs_tag[0], obs_data[0]} !== {exp_tag[0], exp_data[0]}) begin
        n_fail++;
        $display("FAIL single_load_model +%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                 k, obs_tag[0], obs_data[0], exp_tag[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'(BUS_LOAD), 64'(i * 8), 64'd0);
      step();
      n_cmp++;
      if (obs_resp[0] !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_resp #%0d: got %0d want %0d", i, obs_resp[0], i + 1);
      end
    end
    idle_all();
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (obs_tag[0] !== ((k >= 8 && k <= 10) ? 4'(k - 7) : 4'd0)) begin
        n_fail++;
        $display("FAIL b2b_tag +%0d: got %0d want %0d", k, obs_tag[0], (k >= 8 && k <= 10) ? k - 7 : 0);
      end
      n_cmp++;
      if (obs_data[0] !== exp_data[0]) begin
        n_fail++;
        $display("FAIL b2b_data +%0d: got %h want %h", k, obs_data[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_tag_exhaust();
    for (int i = 0; i < 25; i++) begin
      drive(1, 2'(BUS_LOAD), rand_addr(1, $urandom_range(0, 63)), 64'd0);
      step();
      if (i < 15) begin
        n_cmp++;
        if (obs_resp[1] !== 4'(i + 1)) begin
          n_fail++;
          $display("FAIL exhaust_alloc cyc+%0d: got %0d want %0d", i, obs_resp[1], i + 1);
        end
      end else if (i < 20) begin
        n_cmp++;
        if (obs_resp[1] !== 4'd0) begin
          n_fail++;
          $display("FAIL exhaust_reject cyc+%0d: got %0d want 0", i, obs_resp[1]);
        end
      end
      if (i == 20) begin
        n_cmp++;
        if (obs_tag[1] !== 4'd1 || obs_resp[1] !== 4'd0) begin
          n_fail++;
          $display("FAIL exhaust_return cyc+20: got tag=%0d resp=%0d want tag=1 resp=0", obs_tag[1], obs_resp[1]);
        end
      end
      if (i == 21) begin
        n_cmp++;
        if (obs_resp[1] !== 4'd1) begin
          n_fail++;
          $display("FAIL exhaust_realloc cyc+21: got %0d want 1", obs_resp[1]);
        end
      end
      n_cmp++;
      if ({obs_resp[1], obs_tag[1], obs_data[1]} !== {exp_resp[1], exp_tag[1], exp_data[1]}) begin
        n_fail++;
        $display("FAIL exhaust_model cyc+%0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                 i, obs_resp[1], obs_tag[1], obs_data[1], exp_resp[1], exp_tag[1], exp_data[1]);
      end
    end
    idle_all();
    for (int i = 0; i < 25; i++) begin
      step();
      n_cmp++;
      if ({obs_tag[1], obs_data[1]} !== {exp_tag[1], exp_data[1]}) begin
        n_fail++;
        $display("FAIL exhaust_drain cyc=%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                 cyc - 1, obs_tag[1], obs_data[1], exp_tag[1], exp_data[1]);
      end
    end
  endtask

  task automatic test_raw_order();
    int w;
    w = $urandom_range(0, 63);
    drive(0, 2'(BUS_STORE), rand_addr(0, w), 64'd5);
    step();
    idle_all();
    for (int i = 0; i < 12; i++) step();
    drive(0, 2'(BUS_LOAD), rand_addr(0, w), 64'd0);
    step();
    drive(0, 2'(BUS_STORE), rand_addr(0, w), 64'd9);
    step();
    drive(0, 2'(BUS_LOAD), rand_addr(0, w), 64'd0);
    step();
    idle_all();
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k >= 8 && k <= 10) begin
        n_cmp++;
        if (obs_tag[0] !== 4'(k - 7) || obs_data[0] !== ((k == 8) ? 64'd5 : (k == 9) ? 64'd0 : 64'd9)) begin
          n_fail++;
          $display("FAIL raw_order +%0d: got tag=%0d data=%h, want tag=%0d data=%0d",
                   k, obs_tag[0], obs_data[0], k - 7, (k == 8) ? 5 : (k == 9) ? 0 : 9);
        end
      end
      n_cmp++;
      if ({obs_tag[0], obs_data[0]} !== {exp_tag[0], exp_data[0]}) begin
        n_fail++;
        $display("FAIL raw_model +%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                 k, obs_tag[0], obs_data[0], exp_tag[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'(BUS_LOAD), rand_addr(0, i), 64'd0);
      drive(1, 2'(BUS_LOAD), rand_addr(1, i), 64'd0);
      step();
    end
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_tag[d] !== 4'd0 || obs_data[d] !== 64'd0) begin
          n_fail++;
          $display("FAIL midreset_silent dut%0d +%0d: got tag=%0d data=%h, want 0", d, i, obs_tag[d], obs_data[d]);
        end
      end
    end
    drive(0, 2'(BUS_LOAD), rand_addr(0, 7), 64'd0);
    drive(1, 2'(BUS_LOAD), rand_addr(1, 7), 64'd0);
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_resp[d] !== 4'd1) begin
        n_fail++;
        $display("FAIL midreset_realloc dut%0d: got %0d want 1", d, obs_resp[d]);
      end
    end
    idle_all();
    for (int i = 0; i < 25; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({obs_tag[d], obs_data[d]} !== {exp_tag[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL midreset_drain dut%0d cyc=%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                   d, cyc - 1, obs_tag[d], obs_data[d], exp_tag[d], exp_data[d]);
        end
      end
    end
  endtask

  task automatic test_none_cmd();
    drive(0, 2'(BUS_LOAD), rand_addr(0, 1), 64'd0);
    step();
    drive(0, 2'(BUS_STORE), rand_addr(0, 2), 64'h77);
    step();
    drive(0, 2'd3, rand_addr(0, 3), 64'h88);
    step();
    n_cmp++;
    if (obs_resp[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL none_cmd3: got %0d want 0", obs_resp[0]);
    end
    drive(0, 2'(BUS_NONE), rand_addr(0, 3), 64'h99);
    step();
    n_cmp++;
    if (obs_resp[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL none_idle: got %0d want 0", obs_resp[0]);
    end
    drive(0, 2'(BUS_LOAD), rand_addr(0, 3), 64'd0);
    step();
    n_cmp++;
    if (obs_resp[0] !== 4'd3) begin
      n_fail++;
      $display("FAIL none_pool: got %0d want 3", obs_resp[0]);
    end
    idle_all();
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if ({obs_tag[0], obs_data[0]} !== {exp_tag[0], exp_data[0]}) begin
        n_fail++;
        $display("FAIL none_drain cyc=%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                 cyc - 1, obs_tag[0], obs_data[0], exp_tag[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < 2; d++) begin
        drive(d, 2'($urandom_range(0, 3)),
              rand_addr(d, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63)),
              {$urandom, $urandom});
      end
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({obs_resp[d], obs_tag[d], obs_data[d]} !== {exp_resp[d], exp_tag[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                   d, cyc - 1, obs_resp[d], obs_tag[d], obs_data[d], exp_resp[d], exp_tag[d], exp_data[d]);
        end
      end
    end
    rst = 1'b0;
    idle_all();
    for (int i = 0; i < 25; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({obs_tag[d], obs_data[d]} !== {exp_tag[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL random_drain dut%0d cyc=%0d: got tag=%0d data=%h, want tag=%0d data=%h",
                   d, cyc - 1, obs_tag[d], obs_data[d], exp_tag[d], exp_data[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (q_size(d) != 0) begin
        n_fail++;
        $display("FAIL random_leftover dut%0d: got %0d pending, want 0", d, q_size(d));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    @(posedge clk);
    #1;
    test_reset();
    test_preload();
    test_single_load();
    test_back_to_back();
    test_tag_exhaust();
    test_raw_order();
    test_reset_midflight();
    test_none_cmd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
